// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RV32M divide/remainder unit
//
// Purpose: 32-iteration restoring divider for DIV/DIVU/REM/REMU with a fixed
// 34-cycle latency from start to the result pulse, plus a combinational stall
// request for the pipeline control block.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   start_i      request strobe, sampled only in IDLE
//   op_i         funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i   rs1 value
//   divisor_i    rs2 value
//   reg_waddr_i  destination register
//   result_o     quotient or remainder, valid while ready_o=1
//   reg_waddr_o  destination captured at start
//   ready_o      one-cycle completion pulse
//   busy_o       high whenever the unit is not IDLE
//   hold_flag_o  stall request to pipeline control
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_waddr_o,
  output logic            ready_o,
  output logic            busy_o,
  output logic            hold_flag_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] quo_q, quo_d;     // holds |dividend|, shifted out as quotient bits shift in
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            neg_q_q, neg_q_d; // negate quotient
  logic            neg_r_q, neg_r_d; // negate remainder
  logic [XLEN-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  logic            is_signed;
  logic [XLEN-1:0] abs_dvd, abs_dvs;
  logic [XLEN:0]   trial, diff;
  logic            ge;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign is_signed = ~op_i[0];
  assign abs_dvd   = (is_signed && dividend_i[XLEN-1]) ? (~dividend_i + 1'b1) : dividend_i;
  assign abs_dvs   = (is_signed && divisor_i[XLEN-1])  ? (~divisor_i + 1'b1)  : divisor_i;

  assign trial = {rem_q, quo_q[XLEN-1]};
  assign ge    = trial >= {1'b0, dvs_q};
  assign diff  = trial - {1'b0, dvs_q};

  assign quo_fix = neg_q_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = neg_r_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    waddr_d  = waddr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    ready_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CALC;
          cnt_d   = 5'd0;
          op_d    = op_i;
          waddr_d = reg_waddr_i;
          quo_d   = abs_dvd;
          rem_d   = '0;
          dvs_d   = abs_dvs;
          neg_q_d = is_signed & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
          neg_r_d = is_signed & dividend_i[XLEN-1];
        end
      end
      S_CALC: begin
        rem_d = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_END;
      end
      S_END: begin
        // Divide by zero: every trial succeeds, so the remainder ends up as
        // |dividend| and the sign fix restores the original dividend; only
        // the quotient needs an explicit override. Signed overflow
        // (0x80000000 / -1) yields 0x80000000 / 0 from the normal path.
        if (!op_q[1]) result_d = (dvs_q == '0) ? '1 : quo_fix;
        else          result_d = rem_fix;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      waddr_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      waddr_q  <= waddr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // reg_waddr_o follows the destination latched at start only once the
  // result is produced, so it stays stable while busy.
  logic [4:0] waddr_out_q;
  always_ff @(posedge clk) begin
    if (!rst_n)              waddr_out_q <= '0;
    else if (state_q == S_END) waddr_out_q <= waddr_q;
  end

  assign result_o    = result_q;
  assign reg_waddr_o = waddr_out_q;
  assign ready_o     = ready_q;
  assign busy_o      = (state_q != S_IDLE);
  assign hold_flag_o = rst_n & ((start_i & (state_q == S_IDLE)) | busy_o);

endmodule
